bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be:
- WAIT_CYCLES, default 1: bus hold cycles before sampling data; legal 1..15.
- IF_RD_CTRL, default 3'b010: rd_ctrl code issued for instruction fetch.
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  sole clock.
- rst  in  1  reset.
- if_req  in  1  fetch request.
- if_addr  in  64  fetch address.
- if_ack  out  1  fetch done, one-cycle pulse.
- if_rdata  out  64  fetch data.
- if_err  out  1  fetch hit an unmapped address.
- mem_req  in  1  load/store request.
- mem_addr  in  64  load/store address.
- mem_wdata  in  64  store data.
- mem_rd_ctrl  in  3  load control.
- mem_wr_ctrl  in  3  store control.
- mem_ack  out  1  load/store done, one-cycle pulse.
- mem_rdata  out  64  load data.
- mem_err  out  1  load/store hit an unmapped address.
- bus_addr  out  64  system bus address.
- bus_data_in  out  64  system bus write data.
- bus_rd_ctrl  out  3  system bus read control.
- bus_wr_ctrl  out  3  system bus write control.
- bus_data_out  in  64  system bus read data.
- bus_valid  in  1  address decoded.
REQ-003 Clock and reset SHALL be one clock clk with rst synchronous, active-high.

Function
REQ-004 FSM states SHALL be IDLE, ACCESS and RESP, encoded in 2 bits.
REQ-005 In IDLE with any request pending, the arbiter SHALL grant one requester, latch its address, data and controls into registers, load the wait counter with WAIT_CYCLES-1, and enter ACCESS the next cycle.
REQ-006 In ACCESS, bus outputs SHALL drive the latched request and SHALL stay stable for exactly WAIT_CYCLES cycles.
- The counter SHALL decrement each cycle.
- When the counter reaches 0, the arbiter SHALL register bus_data_out and bus_valid and enter RESP.
REQ-007 In RESP, the granted requester's ack SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
- rdata SHALL equal the sampled bus_data_out.
- err SHALL equal the inverse of the sampled bus_valid.
REQ-008 A fetch transaction SHALL drive bus_rd_ctrl=IF_RD_CTRL, bus_wr_ctrl=0 and bus_data_in=0.
REQ-009 Outside ACCESS, bus_rd_ctrl and bus_wr_ctrl SHALL be 0, and bus_addr and bus_data_in SHALL hold their last values.
REQ-010 Latency SHALL be request-to-ack = WAIT_CYCLES+2 cycles when uncontended.
- Back-to-back transactions SHALL have one IDLE cycle between ack and the next grant.
REQ-011 Requesters SHALL hold req high until ack.
- Requester inputs changing after the grant SHALL NOT affect the transaction in flight.
- req deasserted mid-transaction SHALL NOT abort it; the ack is still issued.
REQ-012 rdata and err SHALL hold their value until that port's next ack.
REQ-013 A mem request with both rd_ctrl and wr_ctrl equal to 0 SHALL complete normally with no bus side effect.

Reset
REQ-014 On rst, the FSM SHALL go to IDLE and the counter to 0.
- All outputs SHALL reset to 0.
- The round-robin pointer SHALL reset to favour mem.
REQ-015 rst asserted mid-transaction SHALL abandon the transaction with no ack.

Configuration
REQ-016 Macro BUS_ARB_RR_EN SHALL select the arbitration policy.
- Defined: round-robin. On a simultaneous request, the port not granted last wins, and the pointer updates on every grant.
- Undefined: fixed priority, mem over if, with no pointer register.

Structure
REQ-017 A shared package SHALL hold the FSM state encoding, the grant-id encoding (GNT_IF, GNT_MEM) and the all-zero idle control constant.
REQ-018 A sub-module, bus_arb_grant, SHALL hold the grant selection logic (policy and pointer).

Verification
REQ-019 Fetch alone, WAIT_CYCLES=1, if_addr=0x100, bus_data_out=0x13, bus_valid=1 -> if_ack on cycle 3, if_rdata=0x13, if_err=0.
REQ-020 if_req and mem_req raised on the same cycle, macro undefined -> mem granted first; if granted after the mem ack plus one IDLE cycle.
REQ-021 Both requests held for 4 transactions, BUS_ARB_RR_EN defined -> grants alternate mem, if, mem, if.
REQ-022 Store to 0x80000008 with wdata 0xDEAD and WAIT_CYCLES=3 -> bus_wr_ctrl nonzero for exactly 3 cycles, then mem_ack.
REQ-023 mem_addr=0x60000000 with bus_valid=0 -> mem_ack with mem_err=1; if_err unchanged.
REQ-024 rst raised during ACCESS -> next cycle IDLE, bus controls 0, no ack issued.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-port bus arbiter: FSM state encoding, grant ids
// and the all-zero control code driven onto the bus when it is idle.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  localparam logic [2:0] CTRL_IDLE = 3'b000;

endpackage

// File: rtl/bus_arb_grant.sv
// Grant selection between fetch and load/store ports.
// BUS_ARB_RR_EN selects round-robin; otherwise fixed priority, mem over if.
module bus_arb_grant
  import bus_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic mem_req_i,
  input  logic grant_en_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  assign gnt_valid_o = if_req_i | mem_req_i;

`ifdef BUS_ARB_RR_EN
  logic last_q, last_d;

  // Reset pretends fetch went last so the first tie goes to mem.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= GNT_IF;
    else       last_q <= last_d;
  end

  always_comb begin
    gnt_id_o = GNT_IF;
    if (if_req_i && mem_req_i) gnt_id_o = (last_q == GNT_MEM) ? GNT_IF : GNT_MEM;
    else if (mem_req_i)        gnt_id_o = GNT_MEM;
  end

  always_comb begin
    last_d = last_q;
    if (grant_en_i && gnt_valid_o) last_d = gnt_id_o;
  end
`else
  logic unused_ok;
  assign unused_ok = clk_i ^ rst_i ^ grant_en_i;
  assign gnt_id_o  = mem_req_i ? GNT_MEM : GNT_IF;
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single system bus with a fixed
// WAIT_CYCLES access window. Policy macro BUS_ARB_RR_EN lives in bus_arb_grant.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int         WAIT_CYCLES = 1,
  parameter logic [2:0] IF_RD_CTRL  = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ack,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [2:0]  mem_rd_ctrl,
  input  logic [2:0]  mem_wr_ctrl,
  output logic        mem_ack,
  output logic [63:0] mem_rdata,
  output logic        mem_err,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_data_in,
  output logic [2:0]  bus_rd_ctrl,
  output logic [2:0]  bus_wr_ctrl,
  input  logic [63:0] bus_data_out,
  input  logic        bus_valid
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        gnt_q;
  logic [63:0] addr_q, wdata_q;
  logic [2:0]  rd_q, wr_q;
  logic [63:0] if_rdata_q, mem_rdata_q;
  logic        if_err_q, mem_err_q;
  logic        gnt_valid, gnt_id, grant_en;

  assign grant_en = (state_q == IDLE) && gnt_valid;

  bus_arb_grant u_grant (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_req_i    (if_req),
    .mem_req_i   (mem_req),
    .grant_en_i  (grant_en),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is captured at grant so later requester changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 4'd0;
      gnt_q       <= GNT_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= CTRL_IDLE;
      wr_q        <= CTRL_IDLE;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      mem_rdata_q <= '0;
      mem_err_q   <= 1'b0;
    end else if (grant_en) begin
      gnt_q <= gnt_id;
      cnt_q <= 4'(WAIT_CYCLES - 1);
      if (gnt_id == GNT_MEM) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        rd_q    <= mem_rd_ctrl;
        wr_q    <= mem_wr_ctrl;
      end else begin
        addr_q  <= if_addr;
        wdata_q <= '0;
        rd_q    <= IF_RD_CTRL;
        wr_q    <= CTRL_IDLE;
      end
    end else if (state_q == ACCESS) begin
      if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end else if (gnt_q == GNT_MEM) begin
        mem_rdata_q <= bus_data_out;
        mem_err_q   <= ~bus_valid;
      end else begin
        if_rdata_q <= bus_data_out;
        if_err_q   <= ~bus_valid;
      end
    end
  end

  always_comb begin
    if_ack      = (state_q == RESP) && (gnt_q == GNT_IF);
    mem_ack     = (state_q == RESP) && (gnt_q == GNT_MEM);
    bus_rd_ctrl = (state_q == ACCESS) ? rd_q : CTRL_IDLE;
    bus_wr_ctrl = (state_q == ACCESS) ? wr_q : CTRL_IDLE;
    bus_addr    = addr_q;
    bus_data_in = wdata_q;
    if_rdata    = if_rdata_q;
    if_err      = if_err_q;
    mem_rdata   = mem_rdata_q;
    mem_err     = mem_err_q;
  end

endmodule
